// File: rtl/kms_pkg.sv
// Shared types and constants for the kernel memory sequencer.
// Optional macro KMS_TIMEOUT_EN adds the ERR state used by the RUN watchdog.
package kms_pkg;

   localparam int unsigned KMS_ADDR_WIDTH = 5;
   localparam int unsigned KMS_DATA_WIDTH = 32;
   localparam int unsigned RUN_CYCLES_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
`ifdef KMS_TIMEOUT_EN
      ,
      ST_ERR
`endif
   } state_t;

endpackage

// File: rtl/kms_drain_cursor.sv
// Result window cursor: captures base/count, steps the beat index and
// produces the wrapping RAM2 read address and the registered last flag.
module kms_drain_cursor
   import kms_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = KMS_ADDR_WIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  capture,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH:0]   count,
   input  logic                  advance,
   input  logic                  arm,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last,
   output logic                  count_zero
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         idx_q, idx_d;

   always_comb begin
      base_d  = base_q;
      count_d = count_q;
      idx_d   = idx_q;
      if (capture) begin
         base_d  = base;
         count_d = count;
         idx_d   = '0;
      end else if (advance) begin
         idx_d = idx_q + CW'(1);
      end
   end

   // Address wraps naturally at 2^ADDR_WIDTH; last is only raised while armed
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         addr    <= '0;
         last    <= 1'b0;
      end else begin
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         addr    <= base_d + idx_d[ADDR_WIDTH-1:0];
         last    <= arm && (idx_d == count_d - CW'(1));
      end
   end

   assign count_zero = (count_q == '0);

endmodule

// File: rtl/kernel_mem_sequencer.sv
// Load/run/drain controller for an HLS kernel and its RAM2 debug ports.
// Define KMS_TIMEOUT_EN to add the RUN watchdog, the ERR state and the err port.
module kernel_mem_sequencer
   import kms_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = KMS_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = KMS_DATA_WIDTH
`ifdef KMS_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   rd_base,
   input  logic [ADDR_WIDTH:0]     rd_count,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_last,
   output logic [ADDR_WIDTH-1:0]   dbg_wr_addr,
   output logic [DATA_WIDTH-1:0]   dbg_wr_data,
   output logic                    dbg_wr_en,
   output logic [ADDR_WIDTH-1:0]   dbg_addr,
   input  logic [DATA_WIDTH-1:0]   dbg_data,
   output logic                    kernel_rst,
   input  logic                    kernel_valid,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done,
   output logic [RUN_CYCLES_W-1:0] run_cycles
`ifdef KMS_TIMEOUT_EN
   ,
   output logic                    err
`endif
);

   state_t state_q, state_d;
   logic   start_ok;
   logic   in_acc;
   logic   out_acc;
   logic   cnt_zero;

   assign in_acc   = in_valid && in_ready;
   assign out_acc  = out_valid && out_ready;
   assign out_data = dbg_data;

   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_LOAD;
               start_ok = 1'b1;
            end
         end
         ST_LOAD:  if (in_acc && in_last) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_RUN;
         ST_RUN: begin
            if (kernel_valid)
               state_d = cnt_zero ? ST_DONE : ST_DRAIN;
`ifdef KMS_TIMEOUT_EN
            else if (run_cycles == RUN_CYCLES_W'(TIMEOUT_CYCLES - 1))
               state_d = ST_ERR;
`endif
         end
         ST_DRAIN: if (out_acc && out_last) state_d = ST_DONE;
`ifdef KMS_TIMEOUT_EN
         ST_ERR: begin
            if (start) begin
               state_d  = ST_LOAD;
               start_ok = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         kernel_rst  <= 1'b1;
         in_ready    <= 1'b0;
         dbg_wr_en   <= 1'b0;
         dbg_wr_addr <= '0;
         dbg_wr_data <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         run_cycles  <= '0;
`ifdef KMS_TIMEOUT_EN
         err         <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         kernel_rst <= (state_d != ST_RUN);
         in_ready   <= (state_d == ST_LOAD);
         out_valid  <= (state_d == ST_DRAIN);
         busy       <= state_d inside {ST_LOAD, ST_FLUSH, ST_RUN, ST_DRAIN};
`ifdef KMS_TIMEOUT_EN
         done       <= (state_d == ST_DONE) || (state_d == ST_ERR);
         err        <= (state_d == ST_ERR);
`else
         done       <= (state_d == ST_DONE);
`endif
         dbg_wr_en  <= in_acc;
         if (in_acc) begin
            dbg_wr_addr <= in_addr;
            dbg_wr_data <= in_data;
         end
         if (start_ok)
            run_cycles <= '0;
         else if (state_q == ST_RUN && run_cycles != '1)
            run_cycles <= run_cycles + RUN_CYCLES_W'(1);
      end
   end

   kms_drain_cursor #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_cursor (
      .clk        (clk),
      .rst        (rst),
      .capture    (start_ok),
      .base       (rd_base),
      .count      (rd_count),
      .advance    (out_acc),
      .arm        (state_d == ST_DRAIN),
      .addr       (dbg_addr),
      .last       (out_last),
      .count_zero (cnt_zero)
   );

endmodule

// File: tb/tb_kernel_mem_sequencer.sv
// Directed bench for kernel_mem_sequencer with a behavioural RAM2 model.
// Define KMS_TIMEOUT_EN to also exercise the RUN watchdog (TIMEOUT_CYCLES=16).
module tb_kernel_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  rd_base;
   logic [5:0]  rd_count;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        in_last;
   logic [4:0]  dbg_wr_addr;
   logic [31:0] dbg_wr_data;
   logic        dbg_wr_en;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        kernel_rst;
   logic        kernel_valid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [31:0] run_cycles;
`ifdef KMS_TIMEOUT_EN
   logic        err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem [32];

   always #5 clk = ~clk;

   // RAM2 model: clocked debug write, combinational debug read
   always @(posedge clk) if (dbg_wr_en) mem[dbg_wr_addr] <= dbg_wr_data;
   assign dbg_data = mem[dbg_addr];

   kernel_mem_sequencer #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32)
`ifdef KMS_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .rd_base      (rd_base),
      .rd_count     (rd_count),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .in_last      (in_last),
      .dbg_wr_addr  (dbg_wr_addr),
      .dbg_wr_data  (dbg_wr_data),
      .dbg_wr_en    (dbg_wr_en),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .kernel_rst   (kernel_rst),
      .kernel_valid (kernel_valid),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .run_cycles   (run_cycles)
`ifdef KMS_TIMEOUT_EN
      ,
      .err          (err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [4:0] base, input logic [5:0] cnt);
      rd_base  = base;
      rd_count = cnt;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic send_beat(input logic [4:0] a, input logic [31:0] d, input logic l);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      if (l) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic wait_run(input string tag);
      for (int k = 0; k < 20 && kernel_rst; k++) @(negedge clk);
      check(tag, 32'(kernel_rst), 32'd0);
   endtask

   task automatic wait_out_valid(input string tag);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      check(tag, 32'(out_valid), 32'd1);
   endtask

   logic [31:0] wrap_data [4];
   logic        saw_valid;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      wrap_data[0] = 32'hA30;
      wrap_data[1] = 32'hA31;
      wrap_data[2] = 32'hA00;
      wrap_data[3] = 32'hA01;
      rst = 1'b1; start = 1'b0; rd_base = '0; rd_count = '0;
      in_valid = 1'b0; in_addr = '0; in_data = '0; in_last = 1'b0;
      kernel_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset values
      check("rst_kernel_rst", 32'(kernel_rst), 32'd1);
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_wr_en",      32'(dbg_wr_en),  32'd0);
      check("rst_dbg_addr",   32'(dbg_addr),   32'd0);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_run_cycles", run_cycles,      32'd0);

      // Load then a single-beat drain at rd_base=1
      do_start(5'd1, 6'd1);
      check("load_in_ready", 32'(in_ready), 32'd1);
      check("load_busy",     32'(busy),     32'd1);
      send_beat(5'd1, 32'd9, 1'b0);
      check("wr0_en",   32'(dbg_wr_en),   32'd1);
      check("wr0_addr", 32'(dbg_wr_addr), 32'd1);
      check("wr0_data", dbg_wr_data,      32'd9);
      send_beat(5'd10, 32'd10, 1'b0);
      check("wr1_en",   32'(dbg_wr_en),   32'd1);
      check("wr1_addr", 32'(dbg_wr_addr), 32'd10);
      check("wr1_data", dbg_wr_data,      32'd10);
      send_beat(5'd11, 32'd5, 1'b1);
      check("wr2_en",       32'(dbg_wr_en),   32'd1);
      check("wr2_addr",     32'(dbg_wr_addr), 32'd11);
      check("wr2_data",     dbg_wr_data,      32'd5);
      check("flush_ready",  32'(in_ready),    32'd0);
      check("flush_krst",   32'(kernel_rst),  32'd1);
      @(negedge clk);
      check("run_krst",  32'(kernel_rst), 32'd0);
      check("run_wr_en", 32'(dbg_wr_en),  32'd0);
      repeat (5) @(negedge clk);
      kernel_valid = 1'b1;
      @(negedge clk);
      kernel_valid = 1'b0;
      check("d1_valid",  32'(out_valid),  32'd1);
      check("d1_addr",   32'(dbg_addr),   32'd1);
      check("d1_data",   out_data,        32'd9);
      check("d1_last",   32'(out_last),   32'd1);
      check("d1_cycles", run_cycles,      32'd6);
      check("d1_krst",   32'(kernel_rst), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("d1_done",      32'(done),      32'd1);
      check("d1_valid_off", 32'(out_valid), 32'd0);
      check("d1_busy_off",  32'(busy),      32'd0);
      repeat (2) @(negedge clk);
      check("done_hold_cycles", run_cycles, 32'd6);
      check("done_hold",        32'(done),  32'd1);

      // Wrapping window with backpressure
      do_start(5'd30, 6'd4);
      send_beat(5'd30, wrap_data[0], 1'b0);
      send_beat(5'd31, wrap_data[1], 1'b0);
      send_beat(5'd0,  wrap_data[2], 1'b0);
      send_beat(5'd1,  wrap_data[3], 1'b1);
      wait_run("wrap_run");
      kernel_valid = 1'b1;
      wait_out_valid("wrap_valid");
      kernel_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wrap%0d_addr", i), 32'(dbg_addr), 32'((30 + i) % 32));
         check($sformatf("wrap%0d_data", i), out_data,      wrap_data[i]);
         check($sformatf("wrap%0d_last", i), 32'(out_last), 32'(i == 3));
         @(negedge clk);
         check($sformatf("wrap%0d_hold_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("wrap%0d_hold_data", i),  out_data,       wrap_data[i]);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      check("wrap_done",      32'(done),      32'd1);
      check("wrap_valid_off", 32'(out_valid), 32'd0);

      // Zero-length window skips DRAIN
      do_start(5'd5, 6'd0);
      send_beat(5'd5, 32'h55, 1'b1);
      wait_run("zero_run");
      kernel_valid = 1'b1;
      saw_valid = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         saw_valid |= out_valid;
      end
      kernel_valid = 1'b0;
      check("zero_done",     32'(done),      32'd1);
      check("zero_no_valid", 32'(saw_valid), 32'd0);

      // start ignored in RUN, then reset mid-RUN and rerun
      do_start(5'd7, 6'd1);
      send_beat(5'd7, 32'h77, 1'b1);
      wait_run("rr_run");
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", 32'(busy),       32'd1);
      check("ign_krst", 32'(kernel_rst), 32'd0);
      check("ign_wr",   32'(dbg_wr_en),  32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_krst",   32'(kernel_rst), 32'd1);
      check("mid_busy",   32'(busy),       32'd0);
      check("mid_done",   32'(done),       32'd0);
      check("mid_cycles", run_cycles,      32'd0);
      check("mid_ready",  32'(in_ready),   32'd0);
      do_start(5'd7, 6'd1);
      send_beat(5'd7, 32'h78, 1'b1);
      wait_run("rr2_run");
      kernel_valid = 1'b1;
      wait_out_valid("rr2_valid");
      kernel_valid = 1'b0;
      check("rr2_data",   out_data,      32'h78);
      check("rr2_last",   32'(out_last), 32'd1);
      check("rr2_cycles", run_cycles,    32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rr2_done", 32'(done), 32'd1);

`ifdef KMS_TIMEOUT_EN
      // Watchdog: kernel never signals valid
      do_start(5'd0, 6'd1);
      send_beat(5'd0, 32'h1, 1'b1);
      wait_run("tmo_run");
      for (int k = 0; k < 40 && !done; k++) @(negedge clk);
      check("tmo_err",    32'(err),        32'd1);
      check("tmo_done",   32'(done),       32'd1);
      check("tmo_cycles", run_cycles,      32'd16);
      check("tmo_krst",   32'(kernel_rst), 32'd1);
      do_start(5'd0, 6'd1);
      check("tmo_err_clr", 32'(err),      32'd0);
      check("tmo_load",    32'(in_ready), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
